// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipelined datapath: word width, fetch FSM encoding
// and the reset/bubble constants used by the pipeline registers.
package pipeline_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_STEP       = 32'd4;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'b00,
        FETCH_HOLD = 2'b01,
        FETCH_DROP = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register that catches a memory response
// arriving while decode is stalled.
module fetch_skid_buf
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              unload,
    input  logic              clear,
    input  logic [WORD_W-1:0] wr_instr,
    input  logic [WORD_W-1:0] wr_pc,
    output logic              full,
    output logic [WORD_W-1:0] rd_instr,
    output logic [WORD_W-1:0] rd_pc
);

    logic              full_r;
    logic [WORD_W-1:0] instr_r;
    logic [WORD_W-1:0] pc_r;

    // Occupancy flag; clear and unload take precedence over load.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_r <= 1'b0;
        end else if (clear || unload) begin
            full_r <= 1'b0;
        end else if (load) begin
            full_r <= 1'b1;
        end else begin
            full_r <= full_r;
        end
    end

    // Payload is captured only on a load that is not being cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_r <= {WORD_W{1'b0}};
            pc_r    <= {WORD_W{1'b0}};
        end else if (load && !clear) begin
            instr_r <= wr_instr;
            pc_r    <= wr_pc;
        end else begin
            instr_r <= instr_r;
            pc_r    <= pc_r;
        end
    end

    assign full     = full_r;
    assign rd_instr = instr_r;
    assign rd_pc    = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the single-outstanding imem handshake,
// redirect handling and the IF/ID pipeline register.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
)(
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc,
    output logic [WORD_W-1:0] id_pc4
);

    fetch_state_e      state_r, state_s;
    logic [WORD_W-1:0] pc_r, pc_s;
    logic [WORD_W-1:0] fetch_addr_r;
    logic [WORD_W-1:0] pc_plus4_s;
    logic              can_load_s;

    logic              id_valid_r, id_valid_s;
    logic [WORD_W-1:0] id_instr_r, id_instr_s;
    logic [WORD_W-1:0] id_pc_r, id_pc_s;
    logic [WORD_W-1:0] id_pc4_r, id_pc4_s;

    logic              skid_load_s, skid_unload_s, skid_clear_s;
    logic              skid_full_s;
    logic [WORD_W-1:0] skid_instr_s, skid_pc_s;

    fetch_skid_buf u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load_s),
        .unload   (skid_unload_s),
        .clear    (skid_clear_s),
        .wr_instr (imem_rdata),
        .wr_pc    (pc_r),
        .full     (skid_full_s),
        .rd_instr (skid_instr_s),
        .rd_pc    (skid_pc_s)
    );

    assign pc_plus4_s = pc_r + PC_STEP;
    assign can_load_s = !id_valid_r || id_ready;

    // Next-state, next-PC and IF/ID update; redirect overrides everything.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        id_pc_s       = id_pc_r;
        id_pc4_s      = id_pc4_r;
        skid_load_s   = 1'b0;
        skid_unload_s = 1'b0;
        skid_clear_s  = 1'b0;
        if (id_ready) begin
            id_valid_s = 1'b0;
            id_instr_s = NOP_INSTR;
        end else begin
            id_valid_s = id_valid_r;
            id_instr_s = id_instr_r;
        end

        if (redirect) begin
            pc_s         = redirect_pc;
            id_valid_s   = 1'b0;
            id_instr_s   = NOP_INSTR;
            skid_clear_s = 1'b1;
            // A request still in flight must be drained before refetching.
            if ((state_r != FETCH_HOLD) && !imem_rvalid) begin
                state_s = FETCH_DROP;
            end else begin
                state_s = FETCH_REQ;
            end
        end else begin
            case (state_r)
                FETCH_REQ: begin
                    if (imem_rvalid) begin
                        pc_s = pc_plus4_s;
                        if (can_load_s) begin
                            id_valid_s = 1'b1;
                            id_instr_s = imem_rdata;
                            id_pc_s    = pc_r;
                            id_pc4_s   = pc_plus4_s;
                            state_s    = FETCH_REQ;
                        end else begin
                            skid_load_s = 1'b1;
                            state_s     = FETCH_HOLD;
                        end
                    end else begin
                        state_s = FETCH_REQ;
                    end
                end
                FETCH_HOLD: begin
                    if (id_ready && skid_full_s) begin
                        id_valid_s    = 1'b1;
                        id_instr_s    = skid_instr_s;
                        id_pc_s       = skid_pc_s;
                        id_pc4_s      = skid_pc_s + PC_STEP;
                        skid_unload_s = 1'b1;
                        state_s       = FETCH_REQ;
                    end else if (!skid_full_s) begin
                        state_s = FETCH_REQ;
                    end else begin
                        state_s = FETCH_HOLD;
                    end
                end
                FETCH_DROP: begin
                    if (imem_rvalid) begin
                        state_s = FETCH_REQ;
                    end else begin
                        state_s = FETCH_DROP;
                    end
                end
                default: begin
                    state_s = FETCH_REQ;
                end
            endcase
        end
    end

    // State, PC and fetch address; the address freezes while draining in DROP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= FETCH_REQ;
            pc_r         <= RESET_PC;
            fetch_addr_r <= RESET_PC;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            if (state_s == FETCH_DROP) begin
                fetch_addr_r <= fetch_addr_r;
            end else begin
                fetch_addr_r <= pc_s;
            end
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid_r <= 1'b0;
            id_instr_r <= NOP_INSTR;
            id_pc_r    <= {WORD_W{1'b0}};
            id_pc4_r   <= {WORD_W{1'b0}};
        end else begin
            id_valid_r <= id_valid_s;
            id_instr_r <= id_instr_s;
            id_pc_r    <= id_pc_s;
            id_pc4_r   <= id_pc4_s;
        end
    end

    assign imem_req  = !reset && (state_r != FETCH_HOLD);
    assign imem_addr = fetch_addr_r;
    assign id_valid  = id_valid_r;
    assign id_instr  = id_instr_r;
    assign id_pc     = id_pc_r;
    assign id_pc4    = id_pc4_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-configurable imem responder pushes
// expected IF/ID entries, which are popped and compared when decode accepts them.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, imem_req, imem_rvalid, redirect, id_ready, id_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, id_instr, id_pc, id_pc4;

    typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] req_log[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_accept = 0;
    int          n_coinc  = 0;
    int          lat      = 1;

    fetch_stage dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .id_ready(id_ready), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Memory responder and scoreboard: works on the falling edge so every value
    // seen here is what the next rising edge will sample.
    initial begin
        bit          pend = 1'b0;
        bit          squash = 1'b0;
        int          cnt = 0;
        logic [31:0] req_addr = 32'h0;
        exp_t        e;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (reset) begin
                pend = 1'b0;
                squash = 1'b0;
                exp_q.delete();
            end else begin
                if (pend) begin
                    n_checks++;
                    if (imem_req !== 1'b1 || imem_addr !== req_addr) begin
                        n_errors++;
                        $display("FAIL req_stable: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, req_addr);
                    end
                    if (cnt <= 1) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(req_addr);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end else if (imem_req === 1'b1) begin
                    pend = 1'b1;
                    cnt = lat;
                    req_addr = imem_addr;
                    squash = 1'b0;
                    req_log.push_back(imem_addr);
                end
                if (id_valid === 1'b1 && id_ready === 1'b1) begin
                    n_accept++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL sb_unexpected: got instr=%h pc=%h, expected no instruction", id_instr, id_pc);
                    end else begin
                        e = exp_q.pop_front();
                        if (id_instr !== e.instr || id_pc !== e.pc || id_pc4 !== e.pc + 32'd4) begin
                            n_errors++;
                            $display("FAIL sb_entry: got instr=%h pc=%h pc4=%h, expected instr=%h pc=%h pc4=%h",
                                     id_instr, id_pc, id_pc4, e.instr, e.pc, e.pc + 32'd4);
                        end
                    end
                end
                if (redirect === 1'b1) begin
                    exp_q.delete();
                    if (pend) squash = 1'b1;
                    if (imem_rvalid) n_coinc++;
                end
                if (imem_rvalid && redirect !== 1'b1 && !squash) begin
                    e.instr = mem_word(req_addr);
                    e.pc    = req_addr;
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1; lat = l;
        tick(); tick();
        req_log.delete();
        reset = 1'b0;
    endtask

    task automatic wait_addr(input logic [31:0] a, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            ok = (imem_req === 1'b1 && imem_addr === a);
        end
    endtask

    task automatic wait_valid(input bit match_pc, input logic [31:0] pc, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            ok = (id_valid === 1'b1) && (!match_pc || id_pc === pc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1; lat = 1;
        tick(); tick();
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b, expected 0", imem_req); end
        n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b, expected 0", id_valid); end
        n_checks++; if (id_instr !== NOP) begin n_errors++; $display("FAIL reset_instr: got %h, expected %h", id_instr, NOP); end
        n_checks++; if (id_pc !== 32'h0 || id_pc4 !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h/%h, expected 0/0", id_pc, id_pc4); end
        reset = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_errors++; $display("FAIL reset_first_req: got req=%b addr=%h, expected 1/%h", imem_req, imem_addr, RST_PC); end
    endtask

    task automatic test_free_run();
        int start_acc;
        do_reset(1);
        start_acc = n_accept;
        for (int i = 0; i < 12; i++) tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (req_log.size() <= i || req_log[i] !== 32'(i * 4)) begin
                n_errors++;
                $display("FAIL free_addr%0d: got %h, expected %h", i, (req_log.size() > i) ? req_log[i] : 32'hx, 32'(i * 4));
            end
        end
        n_checks++;
        if (n_accept - start_acc != 5) begin n_errors++; $display("FAIL free_rate: got %0d accepts, expected 5", n_accept - start_acc); end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset(1);
        wait_valid(1'b1, 32'h4, 20, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL stall_wait4: got timeout, expected pc 4 on IF/ID"); return; end
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_instr !== mem_word(32'h4)) begin
                n_errors++; $display("FAIL stall_hold%0d: got valid=%b pc=%h, expected 1/00000004", i, id_valid, id_pc);
            end
        end
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL stall_req_low: got %b, expected 0", imem_req); end
        id_ready = 1'b1;
        tick();
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== mem_word(32'h8)) begin
            n_errors++; $display("FAIL stall_release: got valid=%b pc=%h instr=%h, expected 1/00000008/%h", id_valid, id_pc, id_instr, mem_word(32'h8));
        end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_errors++; $display("FAIL stall_resume: got req=%b addr=%h, expected 1/0000000c", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_drop();
        bit ok;
        do_reset(3);
        wait_addr(32'h10, 60, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL drop_wait10: got timeout, expected request at 00000010"); return; end
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_errors++; $display("FAIL drop_hold_addr: got req=%b addr=%h, expected 1/00000010", imem_req, imem_addr); end
        n_checks++; if (id_valid !== 1'b0 || id_instr !== NOP) begin n_errors++; $display("FAIL drop_flush: got valid=%b instr=%h, expected 0/%h", id_valid, id_instr, NOP); end
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = (imem_req === 1'b1 && imem_addr === 32'h40);
            n_checks++;
            if (id_valid !== 1'b0 || id_instr !== NOP) begin n_errors++; $display("FAIL drop_bubble: got valid=%b instr=%h, expected 0/%h", id_valid, id_instr, NOP); end
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL drop_target: got addr=%h, expected 00000040", imem_addr); end
        wait_valid(1'b0, 32'h0, 10, ok);
        n_checks++;
        if (!ok || id_pc !== 32'h40 || id_instr !== mem_word(32'h40)) begin
            n_errors++; $display("FAIL drop_first: got valid=%b pc=%h instr=%h, expected 1/00000040/%h", id_valid, id_pc, id_instr, mem_word(32'h40));
        end
    endtask

    task automatic test_redirect_rvalid();
        bit ok;
        int c0;
        do_reset(1);
        wait_addr(32'h8, 20, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL coinc_wait8: got timeout, expected request at 00000008"); return; end
        tick();
        c0 = n_coinc;
        redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        n_checks++; if (n_coinc != c0 + 1) begin n_errors++; $display("FAIL coinc_setup: got %0d coincident events, expected %0d", n_coinc - c0, 1); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_errors++; $display("FAIL coinc_addr: got req=%b addr=%h, expected 1/00000080", imem_req, imem_addr); end
        n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL coinc_flush: got %b, expected 0", id_valid); end
        wait_valid(1'b0, 32'h0, 10, ok);
        n_checks++; if (!ok || id_pc !== 32'h80) begin n_errors++; $display("FAIL coinc_first: got valid=%b pc=%h, expected 1/00000080", id_valid, id_pc); end
    endtask

    task automatic test_redirect_hold();
        bit ok;
        do_reset(1);
        wait_valid(1'b1, 32'h4, 20, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL hold_wait4: got timeout, expected pc 4 on IF/ID"); return; end
        id_ready = 1'b0;
        tick(); tick();
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL hold_enter: got req=%b, expected 0", imem_req); end
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        n_checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_errors++; $display("FAIL hold_redirect: got valid=%b req=%b addr=%h, expected 0/1/00000100", id_valid, imem_req, imem_addr);
        end
        id_ready = 1'b1;
        wait_valid(1'b0, 32'h0, 10, ok);
        n_checks++; if (!ok || id_pc !== 32'h100) begin n_errors++; $display("FAIL hold_first: got valid=%b pc=%h, expected 1/00000100", id_valid, id_pc); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset(1);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        wait_valid(1'b0, 32'h0, 12, ok);
        n_checks++; if (!ok || id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0) begin
            n_errors++; $display("FAIL wrap_pc4: got pc=%h pc4=%h, expected fffffffc/00000000", id_pc, id_pc4);
        end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_errors++; $display("FAIL wrap_addr: got req=%b addr=%h, expected 1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_reset_drop();
        bit ok;
        do_reset(3);
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_errors++; $display("FAIL rdrop_enter: got req=%b addr=%h, expected 1/00000000", imem_req, imem_addr); end
        reset = 1'b1;
        tick();
        n_checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin n_errors++; $display("FAIL rdrop_reset: got valid=%b req=%b, expected 0/0", id_valid, imem_req); end
        reset = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_errors++; $display("FAIL rdrop_restart: got req=%b addr=%h, expected 1/%h", imem_req, imem_addr, RST_PC); end
        wait_valid(1'b0, 32'h0, 20, ok);
        n_checks++; if (!ok || id_pc !== RST_PC) begin n_errors++; $display("FAIL rdrop_first: got valid=%b pc=%h, expected 1/%h", id_valid, id_pc, RST_PC); end
    endtask

    task automatic test_reset_hold();
        bit ok;
        do_reset(1);
        wait_valid(1'b1, 32'h4, 20, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL rhold_wait4: got timeout, expected pc 4 on IF/ID"); return; end
        id_ready = 1'b0;
        tick(); tick();
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL rhold_enter: got req=%b, expected 0", imem_req); end
        reset = 1'b1;
        tick();
        n_checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin n_errors++; $display("FAIL rhold_reset: got valid=%b req=%b, expected 0/0", id_valid, imem_req); end
        reset = 1'b0; id_ready = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_errors++; $display("FAIL rhold_restart: got req=%b addr=%h, expected 1/%h", imem_req, imem_addr, RST_PC); end
        wait_valid(1'b0, 32'h0, 20, ok);
        n_checks++; if (!ok || id_pc !== RST_PC) begin n_errors++; $display("FAIL rhold_first: got valid=%b pc=%h, expected 1/%h", id_valid, id_pc, RST_PC); end
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_drop();
        test_redirect_rvalid();
        test_redirect_hold();
        test_wrap();
        test_reset_drop();
        test_reset_hold();
        do_reset(1);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
